// File: rtl/sa_skew_buffer.sv
// ----------------------------------------------------------------------------
// sa_skew_buffer
//   Diagonal skew stage that sits in front of the systolic array edge. One
//   NUM_LANES-wide vector is accepted on every enabled clock; lane i is
//   delayed by i extra cycles, so lane i emerges i+1 enabled edges after
//   capture. This produces the staggered wavefront the PE array expects.
//   The oldest lane also carries a "last" tag, which drives the done pulse.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   global advance; 0 freezes every stage
//   in_valid   in   in_data holds a valid vector this cycle
//   in_last    in   vector is the last of a tile (only when in_valid)
//   in_data    in   lane i = in_data[i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  out  per-lane valid at the array edge
//   out_data   out  skewed lane data, same packing; zero when lane not valid
//   busy       out  some valid word is still held in the buffer
//   done       out  one-cycle pulse when the last-tagged word leaves the
//                   final lane
// ----------------------------------------------------------------------------
module sa_skew_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LANES  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            in_valid,
    input  logic                            in_last,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
    output logic [NUM_LANES-1:0]            out_valid,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
    output logic                            busy,
    output logic                            done
);

    // Per-lane "any valid after this edge" terms, gathered for busy.
    logic [NUM_LANES-1:0] w_lane_busy;
    // Done for the coming edge, produced by the tagged lane.
    logic                 w_done_next;
    logic                 r_busy;
    logic                 r_done;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            localparam int DEPTH = g + 1;

            logic [DEPTH-1:0][DATA_WIDTH-1:0] r_data;
            logic [DEPTH-1:0]                 r_vld;
            logic [DEPTH-1:0]                 w_vld_next;
            logic [DATA_WIDTH-1:0]            w_head;

            // Bubbles enter as zero data so an idle lane always shows zeros.
            assign w_head = in_valid ? in_data[g*DATA_WIDTH +: DATA_WIDTH]
                                     : {DATA_WIDTH{1'b0}};

            // Next-state of the lane valid chain; busy is derived from it so
            // that busy reflects the contents after the edge.
            always_comb begin
                w_vld_next = r_vld;
                if (en) begin
                    w_vld_next[0] = in_valid;
                    for (int k = 1; k < DEPTH; k++) begin
                        w_vld_next[k] = r_vld[k-1];
                    end
                end else begin
                    w_vld_next = r_vld;
                end
            end

            // Lane data/valid shift chain, frozen while en is low.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld  <= {DEPTH{1'b0}};
                    r_data <= {(DEPTH*DATA_WIDTH){1'b0}};
                end else begin
                    r_vld <= w_vld_next;
                    if (en) begin
                        r_data[0] <= w_head;
                        for (int k = 1; k < DEPTH; k++) begin
                            r_data[k] <= r_data[k-1];
                        end
                    end
                end
            end

            assign w_lane_busy[g]                          = |w_vld_next;
            assign out_valid[g]                            = r_vld[DEPTH-1];
            assign out_data[g*DATA_WIDTH +: DATA_WIDTH]    = r_data[DEPTH-1];

            if (g == NUM_LANES - 1) begin : g_tag
                // The tag chain stops one stage short of the tail: the tail
                // "last" bit is represented by r_done itself, which is set on
                // the same edge the tagged word reaches the output.
                logic [DEPTH-2:0] r_last;

                // Last-tag shift chain; a tag is only stored with a valid word.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_last <= {(DEPTH-1){1'b0}};
                    end else if (en) begin
                        r_last[0] <= in_valid & in_last;
                        for (int k = 1; k < DEPTH - 1; k++) begin
                            r_last[k] <= r_last[k-1];
                        end
                    end
                end

                assign w_done_next = en & r_vld[DEPTH-2] & r_last[DEPTH-2];
            end
        end
    endgenerate

    // Status registers: busy mirrors post-edge occupancy, done is the
    // en-qualified arrival of the tagged word at the final lane output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= |w_lane_busy;
            r_done <= w_done_next;
        end
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_sa_skew_buffer.sv
// ----------------------------------------------------------------------------
// tb_sa_skew_buffer
//   Scoreboard bench for sa_skew_buffer with NUM_LANES=4, DATA_WIDTH=16.
//   Every enabled edge pushes the applied vector into a history queue and
//   retires the oldest entry; the expected output of lane i is the entry of
//   age i, done follows the age-3 entry, busy is any valid in the window.
// ----------------------------------------------------------------------------
module tb_sa_skew_buffer;

    localparam int DW = 16;
    localparam int NL = 4;

    typedef struct packed {
        logic          vld;
        logic          last;
        logic [63:0]   data;
    } vec_t;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          en       = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last  = 1'b0;
    logic [63:0]   in_data  = 64'd0;
    logic [NL-1:0] out_valid;
    logic [63:0]   out_data;
    logic          busy;
    logic          done;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t hist[$];
    logic last_en  = 1'b0;

    sa_skew_buffer #(.DATA_WIDTH(DW), .NUM_LANES(NL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        vec_t z;
        z = '0;
        hist.delete();
        for (int k = 0; k < NL; k++) hist.push_back(z);
        last_en = 1'b0;
    endtask

    // Apply one cycle of stimulus, wait for the edge, update the scoreboard.
    task automatic drive(input logic v, input logic l, input logic [63:0] d, input logic e);
        vec_t n;
        en = e; in_valid = v; in_last = l; in_data = d;
        @(posedge clk);
        #1;
        if (e) begin
            n.vld  = v;
            n.last = v & l;
            n.data = v ? d : 64'd0;
            hist.push_back(n);
            void'(hist.pop_front());
        end
        last_en = e;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Expected values: hist[NL-1] is age 0 (newest), hist[0] is age NL-1.
    function automatic logic [NL-1:0] exp_valid();
        logic [NL-1:0] r;
        for (int i = 0; i < NL; i++) r[i] = hist[NL-1-i].vld;
        return r;
    endfunction

    function automatic logic [63:0] exp_data();
        logic [63:0] r;
        logic [63:0] t;
        for (int i = 0; i < NL; i++) begin
            t = hist[NL-1-i].data;
            r[i*DW +: DW] = t[i*DW +: DW];
        end
        return r;
    endfunction

    function automatic logic exp_busy();
        logic r;
        r = 1'b0;
        for (int k = 0; k < NL; k++) r = r | hist[k].vld;
        return r;
    endfunction

    function automatic logic exp_done();
        return last_en & hist[0].vld & hist[0].last;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            en = 1'($urandom()); in_valid = 1'($urandom()); in_last = 1'($urandom());
            in_data = rnd64();
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 4'd0 || out_data !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold c%0d: valid=%h data=%h busy=%b done=%b, required all zero",
                         c, out_valid, out_data, busy, done);
            end
        end
        rst_n = 1'b1;
        model_reset();
        drive(1'b1, 1'b0, 64'h0044_0033_0022_0011, 1'b1);
        drive(1'b1, 1'b0, 64'h0088_0077_0066_0055, 1'b1);
        n_checks++;
        if (out_valid !== exp_valid() || out_data !== exp_data() || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_preload: valid=%h data=%h busy=%b, required valid=%h data=%h busy=1",
                     out_valid, out_data, busy, exp_valid(), exp_data());
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 4'd0 || out_data !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: valid=%h data=%h busy=%b done=%b, required all zero",
                     out_valid, out_data, busy, done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        int done_at;
        done_at = -1;
        for (int c = 1; c <= 7; c++) begin
            if (c == 1) drive(1'b1, 1'b1, 64'h0004_0003_0002_0001, 1'b1);
            else        drive(1'b0, 1'b0, rnd64(), 1'b1);
            n_checks++;
            if (out_valid !== exp_valid() || out_data !== exp_data()) begin
                n_fail++;
                $display("FAIL single c%0d lanes: valid=%h data=%h, required valid=%h data=%h",
                         c, out_valid, out_data, exp_valid(), exp_data());
            end
            n_checks++;
            if (busy !== exp_busy()) begin
                n_fail++;
                $display("FAIL single c%0d busy: got %b, required %b", c, busy, exp_busy());
            end
            n_checks++;
            if (done !== exp_done()) begin
                n_fail++;
                $display("FAIL single c%0d done: got %b, required %b", c, done, exp_done());
            end
            if (done === 1'b1 && done_at < 0) done_at = c;
        end
        n_checks++;
        if (done_at != 4) begin
            n_fail++;
            $display("FAIL single done_cycle: got %0d, required 4", done_at);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] vecs [3];
        int dones;
        int busy_drop;
        vecs[0] = 64'h0004_0003_0002_0001;
        vecs[1] = 64'h0008_0007_0006_0005;
        vecs[2] = 64'h000C_000B_000A_0009;
        dones = 0;
        busy_drop = -1;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 3) drive(1'b1, (c == 3), vecs[c-1], 1'b1);
            else        drive(1'b0, 1'b0, 64'd0, 1'b1);
            n_checks++;
            if (out_valid !== exp_valid() || out_data !== exp_data()) begin
                n_fail++;
                $display("FAIL b2b c%0d lanes: valid=%h data=%h, required valid=%h data=%h",
                         c, out_valid, out_data, exp_valid(), exp_data());
            end
            n_checks++;
            if (busy !== exp_busy() || done !== exp_done()) begin
                n_fail++;
                $display("FAIL b2b c%0d status: busy=%b done=%b, required busy=%b done=%b",
                         c, busy, done, exp_busy(), exp_done());
            end
            if (done === 1'b1) dones++;
            if (busy === 1'b0 && busy_drop < 0) busy_drop = c;
        end
        n_checks++;
        if (dones != 1 || busy_drop != 7) begin
            n_fail++;
            $display("FAIL b2b summary: dones=%0d busy_drop=c%0d, required dones=1 busy_drop=c7",
                     dones, busy_drop);
        end
    endtask

    task automatic test_stall();
        int done_at;
        logic e;
        done_at = -1;
        for (int c = 1; c <= 8; c++) begin
            e = !(c == 3 || c == 4);
            if (c == 1)      drive(1'b1, 1'b1, 64'h0004_0003_0002_0001, 1'b1);
            else if (!e)     drive(1'b1, 1'b1, rnd64(), 1'b0);
            else             drive(1'b0, 1'b0, rnd64(), 1'b1);
            n_checks++;
            if (out_valid !== exp_valid() || out_data !== exp_data()) begin
                n_fail++;
                $display("FAIL stall step%0d lanes: valid=%h data=%h, required valid=%h data=%h",
                         c, out_valid, out_data, exp_valid(), exp_data());
            end
            n_checks++;
            if (busy !== exp_busy() || done !== exp_done()) begin
                n_fail++;
                $display("FAIL stall step%0d status: busy=%b done=%b, required busy=%b done=%b",
                         c, busy, done, exp_busy(), exp_done());
            end
            if (done === 1'b1 && done_at < 0) done_at = c;
        end
        n_checks++;
        if (done_at != 6) begin
            n_fail++;
            $display("FAIL stall done_step: got %0d, required 6", done_at);
        end
    endtask

    task automatic test_bubble();
        for (int c = 1; c <= 7; c++) begin
            if (c == 1)      drive(1'b1, 1'b0, 64'hA004_A003_A002_A001, 1'b1);
            else if (c == 2) drive(1'b0, 1'b1, rnd64(), 1'b1);
            else if (c == 3) drive(1'b1, 1'b1, 64'hB004_B003_B002_B001, 1'b1);
            else             drive(1'b0, 1'b0, rnd64(), 1'b1);
            n_checks++;
            if (out_valid !== exp_valid() || out_data !== exp_data()) begin
                n_fail++;
                $display("FAIL bubble c%0d lanes: valid=%h data=%h, required valid=%h data=%h",
                         c, out_valid, out_data, exp_valid(), exp_data());
            end
            n_checks++;
            if (busy !== exp_busy() || done !== exp_done()) begin
                n_fail++;
                $display("FAIL bubble c%0d status: busy=%b done=%b, required busy=%b done=%b",
                         c, busy, done, exp_busy(), exp_done());
            end
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        drive(1'b1, 1'b1, 64'h0004_0003_0002_0001, 1'b1);
        drive(1'b0, 1'b0, 64'd0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 4'd0 || out_data !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid clear: valid=%h data=%h busy=%b done=%b, required all zero",
                     out_valid, out_data, busy, done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int c = 1; c <= 6; c++) begin
            drive(1'b0, 1'b0, rnd64(), 1'b1);
            n_checks++;
            if (out_valid !== exp_valid() || out_data !== exp_data() ||
                busy !== exp_busy() || done !== exp_done()) begin
                n_fail++;
                $display("FAIL reset_mid c%0d: valid=%h data=%h busy=%b done=%b, required valid=%h data=%h busy=%b done=%b",
                         c, out_valid, out_data, busy, done, exp_valid(), exp_data(), exp_busy(), exp_done());
            end
            if (done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL reset_mid dones: got %0d, required 0", dones);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_bubble();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
